// File: rtl/dac_spi_frame_rx.sv
// dac_spi_frame_rx: receive-side decoder for the 24-bit DAC serial frames
// (DAC_SYNC / DAC_SCLK / DAC_DIN). The three lines are oversampled in the
// dataclk domain. Each frame is rebuilt into its power-down field and its
// 16-bit code, and the result is handed to a debug consumer over valid/ready.
// The decoder flags short, long and stalled frames.
//
// Optional feature: define DAC_RX_STATS_EN to add the saturating
// rx_frame_count and rx_err_count outputs.
`timescale 1ns/1ps

module dac_spi_frame_rx #(
  parameter int SYNC_STAGES    = 2,     // synchroniser depth, 2..4
  parameter int FRAME_BITS     = 24,    // SCLK falling edges per legal frame
  parameter int TIMEOUT_CYCLES = 1024   // allowed gap between SCLK falls
) (
  input  logic        dataclk,
  input  logic        reset,
  input  logic        DAC_SYNC,
  input  logic        DAC_SCLK,
  input  logic        DAC_DIN,
  output logic [15:0] rx_word,
  output logic [1:0]  rx_pd,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_overrun,
  output logic        rx_frame_err,
  output logic [1:0]  rx_err_code,
  output logic        rx_busy
`ifdef DAC_RX_STATS_EN
  ,
  output logic [15:0] rx_frame_count,
  output logic [15:0] rx_err_count
`endif
);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_TAIL  = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_SHORT   = 2'b01,
    ERR_LONG    = 2'b10,
    ERR_TIMEOUT = 2'b11
  } rx_err_e;

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  // Only pd + word (18 bits) survive. The last of those bits arrives on the
  // capturing edge, so 17 bits are held. Bits [23:18] shift out of the top.
  localparam int KEEP_BITS = 17;

  // Synchroniser chains, history flops and registered edge pulses.
  logic [SYNC_STAGES-1:0] sync_meta_q, sclk_meta_q, din_meta_q;
  logic                   sync_hist_q, sclk_hist_q;
  logic                   sync_fall_q, sync_rise_q, sclk_fall_q, din_q;
  logic                   sync_s, sclk_s, din_s;

  assign sync_s = sync_meta_q[SYNC_STAGES-1];
  assign sclk_s = sclk_meta_q[SYNC_STAGES-1];
  assign din_s  = din_meta_q[SYNC_STAGES-1];

  // Frame state.
  rx_state_e              state_q;
  logic [KEEP_BITS-1:0]   shift_q;
  logic [KEEP_BITS:0]     shift_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]        to_cnt_q;
  logic                   long_seen_q;
  logic [15:0]            rx_word_q;
  logic [1:0]             rx_pd_q;
  logic                   rx_valid_q, rx_overrun_q, rx_frame_err_q, rx_busy_q;
  rx_err_e                err_code_q, err_code_c;
  logic                   capture_c, short_c, long_c, timeout_c, to_expired_c;
  logic                   err_event_c;

  assign shift_d   = {shift_q, din_q};
  assign bit_cnt_d = bit_cnt_q + 1'b1;

  // Synchronise the serial lines and register the edge strobes with the
  // DIN sample taken on the same cycle.
  // NOTE: clocked blocks use non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      sync_meta_q <= '0;
      sclk_meta_q <= '0;
      din_meta_q  <= '0;
      sync_hist_q <= 1'b0;
      sclk_hist_q <= 1'b0;
      sync_fall_q <= 1'b0;
      sync_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      din_q       <= 1'b0;
    end else begin
      sync_meta_q <= {sync_meta_q[SYNC_STAGES-2:0], DAC_SYNC};
      sclk_meta_q <= {sclk_meta_q[SYNC_STAGES-2:0], DAC_SCLK};
      din_meta_q  <= {din_meta_q[SYNC_STAGES-2:0], DAC_DIN};
      sync_hist_q <= sync_s;
      sclk_hist_q <= sclk_s;
      sync_fall_q <= sync_hist_q & ~sync_s;
      sync_rise_q <= ~sync_hist_q & sync_s;
      sclk_fall_q <= sclk_hist_q & ~sclk_s;
      din_q       <= din_s;
    end
  end

  // Decode this cycle's frame events: capture, short, long and timeout.
  // NOTE: every always_comb output gets a default first, so no path can
  // infer a latch.
  always_comb begin
    capture_c    = 1'b0;
    short_c      = 1'b0;
    long_c       = 1'b0;
    timeout_c    = 1'b0;
    err_code_c   = ERR_NONE;
    to_expired_c = (to_cnt_q == TO_LAST) && !sclk_fall_q && !sync_rise_q;
    case (state_q)
      RX_SHIFT: begin
        capture_c = sclk_fall_q && (bit_cnt_q == LAST_BIT);
        short_c   = sync_rise_q && !capture_c;
        timeout_c = to_expired_c;
      end
      RX_TAIL: begin
        long_c    = sclk_fall_q && !long_seen_q;
        timeout_c = to_expired_c;
      end
      default: ;
    endcase
    if (short_c)        err_code_c = ERR_SHORT;
    else if (long_c)    err_code_c = ERR_LONG;
    else if (timeout_c) err_code_c = ERR_TIMEOUT;
    err_event_c = short_c | long_c | timeout_c;
  end

  // Frame FSM with registered outputs, error reporting and the handshake.
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      state_q        <= RX_IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      to_cnt_q       <= '0;
      long_seen_q    <= 1'b0;
      rx_word_q      <= '0;
      rx_pd_q        <= '0;
      rx_valid_q     <= 1'b0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
      err_code_q     <= ERR_NONE;
      rx_busy_q      <= 1'b0;
    end else begin
      rx_frame_err_q <= err_event_c;
      if (err_event_c) err_code_q <= err_code_c;
      // A capture later in this block overrides the handshake clear.
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      case (state_q)
        RX_IDLE: begin
          if (sync_fall_q) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            to_cnt_q    <= '0;
            long_seen_q <= 1'b0;
            state_q     <= RX_SHIFT;
            rx_busy_q   <= 1'b1;
          end
        end
        RX_SHIFT: begin
          if (capture_c) begin
            rx_pd_q    <= shift_d[17:16];
            rx_word_q  <= shift_d[15:0];
            rx_valid_q <= 1'b1;
            if (rx_valid_q && !rx_ready) rx_overrun_q <= 1'b1;
            bit_cnt_q  <= bit_cnt_d;
            to_cnt_q   <= '0;
            if (sync_rise_q) begin
              state_q   <= RX_IDLE;
              rx_busy_q <= 1'b0;
            end else begin
              state_q   <= RX_TAIL;
            end
          end else if (short_c) begin
            state_q   <= RX_IDLE;
            rx_busy_q <= 1'b0;
          end else if (sclk_fall_q) begin
            shift_q   <= shift_d[KEEP_BITS-1:0];
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= '0;
          end else if (timeout_c) begin
            state_q   <= RX_IDLE;
            rx_busy_q <= 1'b0;
          end else begin
            to_cnt_q  <= to_cnt_q + 1'b1;
          end
        end
        RX_TAIL: begin
          if (long_c) long_seen_q <= 1'b1;
          if (sync_rise_q) begin
            state_q   <= RX_IDLE;
            rx_busy_q <= 1'b0;
          end else if (sclk_fall_q) begin
            to_cnt_q  <= '0;
          end else if (timeout_c) begin
            state_q   <= RX_IDLE;
            rx_busy_q <= 1'b0;
          end else begin
            to_cnt_q  <= to_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= RX_IDLE;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_word      = rx_word_q;
  assign rx_pd        = rx_pd_q;
  assign rx_valid     = rx_valid_q;
  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_err_code  = err_code_q;
  assign rx_busy      = rx_busy_q;

`ifdef DAC_RX_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;

  // Saturating counters of good captures and reported errors.
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (capture_c && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (err_event_c && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign rx_frame_count = frame_cnt_q;
  assign rx_err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_dac_spi_frame_rx.sv
// Directed testbench for dac_spi_frame_rx. Pins are driven 1 ns after the
// rising edge of dataclk, and outputs are sampled on the falling edge.
`timescale 1ns/1ps

module tb_dac_spi_frame_rx;

  logic        dataclk = 1'b0;
  logic        reset;
  logic        DAC_SYNC, DAC_SCLK, DAC_DIN, rx_ready;
  logic [15:0] rx_word;
  logic [1:0]  rx_pd, rx_err_code;
  logic        rx_valid, rx_overrun, rx_frame_err, rx_busy;
`ifdef DAC_RX_STATS_EN
  logic [15:0] rx_frame_count, rx_err_count;
`endif

  int checks = 0;
  int errors = 0;
  int err_total = 0;   // dataclk cycles with rx_frame_err high
  int base;

  dac_spi_frame_rx dut (
    .dataclk     (dataclk),
    .reset       (reset),
    .DAC_SYNC    (DAC_SYNC),
    .DAC_SCLK    (DAC_SCLK),
    .DAC_DIN     (DAC_DIN),
    .rx_word     (rx_word),
    .rx_pd       (rx_pd),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err),
    .rx_err_code (rx_err_code),
    .rx_busy     (rx_busy)
`ifdef DAC_RX_STATS_EN
    ,
    .rx_frame_count(rx_frame_count),
    .rx_err_count  (rx_err_count)
`endif
  );

  always #5 dataclk = ~dataclk;

  always @(negedge dataclk) if (rx_frame_err === 1'b1) err_total++;

  task automatic tick(input int n);
    repeat (n) begin @(posedge dataclk); #1; end
  endtask

  task automatic start_frame();
    DAC_SYNC = 1'b0;
    tick(4);
  endtask

  // Send the n low bits of data MSB first, with an SCLK period of 8 dataclk.
  task automatic send_bits(input logic [31:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      DAC_SCLK = 1'b1;
      DAC_DIN  = data[i];
      tick(4);
      DAC_SCLK = 1'b0;
      tick(4);
    end
  endtask

  task automatic end_frame();
    tick(4);
    DAC_SYNC = 1'b1;
    DAC_SCLK = 1'b1;
    tick(8);
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; DAC_SYNC = 1'b1; DAC_SCLK = 1'b1; DAC_DIN = 1'b0; rx_ready = 1'b0;
    tick(3);
    @(negedge dataclk);
    checks++; if (rx_word !== 16'h0) begin errors++; $display("FAIL reset_word: got %h expected 0000", rx_word); end
    checks++; if (rx_pd !== 2'b00) begin errors++; $display("FAIL reset_pd: got %b expected 00", rx_pd); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", rx_frame_err); end
    checks++; if (rx_err_code !== 2'b00) begin errors++; $display("FAIL reset_err_code: got %b expected 00", rx_err_code); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    tick(1);
    reset = 1'b0;
    tick(8);
  endtask

  // Frame 0x008000 with rx_ready high. The last SCLK fall at the pin comes
  // just after edge k0, so rx_valid must rise at edge k0+4 for one cycle.
  task automatic test_basic();
    rx_ready = 1'b1;
    base = err_total;
    start_frame();
    send_bits(32'h0000_4000, 23);
    DAC_SCLK = 1'b1; DAC_DIN = 1'b0;
    tick(4);
    DAC_SCLK = 1'b0;
    repeat (4) @(negedge dataclk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: valid got %b expected 0", rx_valid); end
    @(negedge dataclk);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: valid got %b expected 1", rx_valid); end
    checks++; if (rx_word !== 16'h8000) begin errors++; $display("FAIL basic_word: got %h expected 8000", rx_word); end
    checks++; if (rx_pd !== 2'b00) begin errors++; $display("FAIL basic_pd: got %b expected 00", rx_pd); end
    @(negedge dataclk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: valid got %b expected 0", rx_valid); end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_tail: got %b expected 1", rx_busy); end
    tick(1);
    end_frame();
    @(negedge dataclk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b expected 0", rx_busy); end
    checks++; if (err_total - base !== 0) begin errors++; $display("FAIL basic_no_err: pulses got %0d expected 0", err_total - base); end
  endtask

  task automatic test_overrun();
    rx_ready = 1'b0;
    base = err_total;
    start_frame(); send_bits(32'h0003_FFFF, 24); end_frame();
    @(negedge dataclk);
    checks++; if (rx_pd !== 2'b11) begin errors++; $display("FAIL ovr_pd1: got %b expected 11", rx_pd); end
    checks++; if (rx_word !== 16'hFFFF) begin errors++; $display("FAIL ovr_word1: got %h expected ffff", rx_word); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: got %b expected 0", rx_overrun); end
    tick(1);
    start_frame(); send_bits(32'h0000_0123, 24); end_frame();
    @(negedge dataclk);
    checks++; if (rx_pd !== 2'b00) begin errors++; $display("FAIL ovr_pd2: got %b expected 00", rx_pd); end
    checks++; if (rx_word !== 16'h0123) begin errors++; $display("FAIL ovr_word2: got %h expected 0123", rx_word); end
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", rx_overrun); end
    tick(20);
    @(negedge dataclk);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_hold: got %b expected 1", rx_valid); end
    tick(1);
    pulse_ready();
    @(negedge dataclk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_clear: got %b expected 0", rx_valid); end
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", rx_overrun); end
    checks++; if (err_total - base !== 0) begin errors++; $display("FAIL ovr_no_err: pulses got %0d expected 0", err_total - base); end
  endtask

  task automatic test_short();
    base = err_total;
    tick(1);
    start_frame(); send_bits(32'h0000_02AA, 10); end_frame();
    @(negedge dataclk);
    checks++; if (err_total - base !== 1) begin errors++; $display("FAIL short_pulse: high cycles got %0d expected 1", err_total - base); end
    checks++; if (rx_err_code !== 2'b01) begin errors++; $display("FAIL short_code: got %b expected 01", rx_err_code); end
    checks++; if (rx_word !== 16'h0123) begin errors++; $display("FAIL short_word_kept: got %h expected 0123", rx_word); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL short_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL short_busy: got %b expected 0", rx_busy); end
  endtask

  // 26 edges: the first 24 carry 0x00ABCD, followed by two extra bits.
  task automatic test_long();
    rx_ready = 1'b0;
    base = err_total;
    tick(1);
    start_frame(); send_bits(32'h0002_AF37, 26); end_frame();
    @(negedge dataclk);
    checks++; if (rx_word !== 16'hABCD) begin errors++; $display("FAIL long_word: got %h expected abcd", rx_word); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL long_valid: got %b expected 1", rx_valid); end
    checks++; if (err_total - base !== 1) begin errors++; $display("FAIL long_pulse: high cycles got %0d expected 1", err_total - base); end
    checks++; if (rx_err_code !== 2'b10) begin errors++; $display("FAIL long_code: got %b expected 10", rx_err_code); end
    tick(1);
    pulse_ready();
  endtask

  // Stall after 5 edges. The error must appear 1024 cycles after the edge
  // reaches the FSM, which is pin edge + 4 + 1024.
  task automatic test_timeout();
    base = err_total;
    start_frame();
    send_bits(32'h0000_000A, 4);
    DAC_SCLK = 1'b1; DAC_DIN = 1'b1;
    tick(4);
    DAC_SCLK = 1'b0;
    repeat (1028) @(negedge dataclk);
    checks++; if (rx_frame_err !== 1'b0 || err_total - base !== 0) begin errors++; $display("FAIL timeout_early: err got %b pulses %0d expected 0", rx_frame_err, err_total - base); end
    @(negedge dataclk);
    checks++; if (rx_frame_err !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b expected 1", rx_frame_err); end
    checks++; if (rx_err_code !== 2'b11) begin errors++; $display("FAIL timeout_code: got %b expected 11", rx_err_code); end
    @(negedge dataclk);
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL timeout_one_cycle: got %b expected 0", rx_frame_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", rx_busy); end
    tick(1);
    DAC_SYNC = 1'b1; DAC_SCLK = 1'b1;
    tick(8);
    start_frame(); send_bits(32'h0001_55AA, 24); end_frame();
    @(negedge dataclk);
    checks++; if (rx_word !== 16'h55AA) begin errors++; $display("FAIL timeout_next_word: got %h expected 55aa", rx_word); end
    checks++; if (rx_pd !== 2'b01) begin errors++; $display("FAIL timeout_next_pd: got %b expected 01", rx_pd); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL timeout_next_valid: got %b expected 1", rx_valid); end
    checks++; if (err_total - base !== 1) begin errors++; $display("FAIL timeout_err_total: pulses got %0d expected 1", err_total - base); end
    tick(1);
    pulse_ready();
  endtask

  task automatic test_reset_mid();
    base = err_total;
    start_frame();
    send_bits(32'h0000_0FFF, 12);
    reset = 1'b1;
    tick(2);
    @(negedge dataclk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", rx_busy); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun: got %b expected 0", rx_overrun); end
    checks++; if (rx_word !== 16'h0) begin errors++; $display("FAIL rmid_word: got %h expected 0000", rx_word); end
    tick(1);
    reset = 1'b0;
    DAC_SYNC = 1'b1; DAC_SCLK = 1'b1;
    tick(8);
    start_frame(); send_bits(32'h0000_1234, 24); end_frame();
    @(negedge dataclk);
    checks++; if (rx_word !== 16'h1234) begin errors++; $display("FAIL rmid_next_word: got %h expected 1234", rx_word); end
    checks++; if (rx_pd !== 2'b00) begin errors++; $display("FAIL rmid_next_pd: got %b expected 00", rx_pd); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rmid_next_valid: got %b expected 1", rx_valid); end
    checks++; if (err_total - base !== 0) begin errors++; $display("FAIL rmid_no_err: pulses got %0d expected 0", err_total - base); end
`ifdef DAC_RX_STATS_EN
    checks++; if (rx_frame_count !== 16'd1) begin errors++; $display("FAIL rmid_frame_count: got %0d expected 1", rx_frame_count); end
    checks++; if (rx_err_count !== 16'd0) begin errors++; $display("FAIL rmid_err_count: got %0d expected 0", rx_err_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_short();
    test_long();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
